// File: rtl/haraka_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : haraka_pkg
//  Purpose  : Shared types and constants for the Haraka-S sponge squeeze path.
//             Holds the squeeze FSM state encoding, the rate geometry and the
//             helper that masks the unused tail bits of the final digest byte.
//  Contents : RATE_BITS, RATE_BYTES, squeeze_state_t, last_byte_mask()
//  Revision : 1.0 - initial release
// ============================================================================
package haraka_pkg;

  localparam int RATE_BITS  = 256;
  localparam int RATE_BYTES = RATE_BITS / 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    FIN  = 3'd4
  } squeeze_state_t;

  // Mask for the last digest byte: keep only the top 'partial' bits, which
  // are the valid digest bits when the length is not a whole number of bytes.
  // partial == 0 means the last byte is complete.
  function automatic logic [7:0] last_byte_mask(input logic [2:0] partial);
    logic [7:0] ones;
    ones = 8'hFF;
    if (partial == 3'd0) begin
      return ones;
    end
    return ~(ones >> partial);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_shift_out.sv
`default_nettype none
// ============================================================================
//  Module   : byte_shift_out
//  Purpose  : Rate-block shift register for the squeeze transmitter. Loads a
//             whole block in one cycle and shifts it left by one byte per
//             shift request; the most significant byte is always tapped out.
//  Ports    : internal_clk  - clock
//             reset         - asynchronous active-high reset (clears register)
//             load_i        - load load_data_i (has priority over shift_i)
//             load_data_i   - block to load, WIDTH bits
//             shift_i       - shift left by 8, zero fill
//             byte_o        - current top byte of the register
//  Revision : 1.0 - initial release
// ============================================================================
module byte_shift_out
  import haraka_pkg::*;
#(
  parameter int WIDTH = RATE_BITS
) (
  input  logic             internal_clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  output logic [7:0]       byte_o
);

  logic [WIDTH-1:0] shreg_q;

  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= load_data_i;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[WIDTH-9:0], 8'h00};
    end
  end

  assign byte_o = shreg_q[WIDTH-1 -: 8];

endmodule
`default_nettype wire

// File: rtl/haraka_squeeze_tx.sv
`default_nettype none
// ============================================================================
//  Module   : haraka_squeeze_tx
//  Purpose  : Squeeze-side transmitter of the Haraka-S sponge. Emits
//             ceil(digest_length/8) digest bytes MSB-first from successive
//             rate blocks over a valid/ready byte stream, requesting one
//             permutation per additional block.
//  Ports    : internal_clk, reset (async, active-high)
//             start, digest_length, rate_in      - squeeze request + 1st block
//             rate_valid / perm_req              - permutation handshake
//             byte_out, byte_valid, byte_ready,
//             byte_last                          - digest byte stream
//             busy, done                         - status
//  Revision : 1.0 - initial release
// ============================================================================
module haraka_squeeze_tx #(
  parameter int RATE_BITS = 256,
  parameter int LEN_W     = 64
) (
  input  logic                 internal_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     digest_length,
  input  logic [RATE_BITS-1:0] rate_in,
  input  logic                 rate_valid,
  output logic                 perm_req,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 byte_last,
  output logic                 busy,
  output logic                 done
);

  import haraka_pkg::*;

  localparam int BLK_BYTES = RATE_BITS / 8;
  localparam int BLK_W     = $clog2(BLK_BYTES);
  localparam int BL_W      = LEN_W - 2;

  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLK_BYTES - 1);
  localparam logic [BL_W-1:0]  ONE_BL   = BL_W'(1);

  squeeze_state_t    state_q;
  logic [BL_W-1:0]   bytes_left_q;
  logic [2:0]        partial_q;
  logic [BLK_W-1:0]  blk_cnt_q;
  logic              byte_valid_q;
  logic              perm_req_q;
  logic              busy_q;
  logic              done_q;

  logic [BL_W-1:0]   bytes_left_init;
  logic              shreg_load;
  logic              shreg_shift;
  logic [7:0]        tap_byte;
  logic              last_now;
  logic [7:0]        out_mask;

  // Byte count rounded up: whole bytes plus one if any tail bits remain.
  // Done this way rather than (len+7)>>3 so a maximal length cannot wrap.
  assign bytes_left_init = BL_W'(digest_length[LEN_W-1:3])
                         + BL_W'(|digest_length[2:0]);

  assign shreg_load  = ((state_q == IDLE) && start && (digest_length != '0))
                    || ((state_q == WAIT) && rate_valid);
  assign shreg_shift = (state_q == SEND) && byte_ready;

  byte_shift_out #(
    .WIDTH (RATE_BITS)
  ) u_shift (
    .internal_clk (internal_clk),
    .reset        (reset),
    .load_i       (shreg_load),
    .load_data_i  (rate_in),
    .shift_i      (shreg_shift),
    .byte_o       (tap_byte)
  );

  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bytes_left_q <= '0;
      partial_q    <= '0;
      blk_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
      perm_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      perm_req_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // A previous short digest can leave the block counter mid-way;
            // every squeeze starts on a fresh block.
            blk_cnt_q <= '0;
            if (digest_length == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              bytes_left_q <= bytes_left_init;
              partial_q    <= digest_length[2:0];
              state_q      <= SEND;
              byte_valid_q <= 1'b1;
              busy_q       <= 1'b1;
            end
          end
        end
        SEND: begin
          if (byte_ready) begin
            bytes_left_q <= bytes_left_q - ONE_BL;
            blk_cnt_q    <= blk_cnt_q + 1'b1;
            // Final byte wins over the block boundary, so an exact multiple
            // of the block size never requests a useless permutation.
            if (bytes_left_q == ONE_BL) begin
              state_q      <= FIN;
              byte_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else if (blk_cnt_q == LAST_BLK) begin
              state_q      <= REQ;
              byte_valid_q <= 1'b0;
              perm_req_q   <= 1'b1;
            end
          end
        end
        REQ: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (rate_valid) begin
            blk_cnt_q    <= '0;
            state_q      <= SEND;
            byte_valid_q <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          byte_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign last_now = (bytes_left_q == ONE_BL);
  assign out_mask = last_now ? last_byte_mask(partial_q) : 8'hFF;

  // Outputs are forced to zero outside SEND so the stream is quiet at idle.
  assign byte_out   = byte_valid_q ? (tap_byte & out_mask) : 8'h00;
  assign byte_last  = byte_valid_q && last_now;
  assign byte_valid = byte_valid_q;
  assign perm_req   = perm_req_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire
